// File: rtl/act_pool_2x2.sv
// act_pool_2x2: streaming leaky ReLU followed by optional 2x2 stride-2 max
// pooling over one channel plane at a time in raster order. Every beat is
// accepted; results appear a fixed two cycles after the producing beat.
module act_pool_2x2 #(
  parameter int DW    = 16,
  parameter int MAX_W = 416,
  parameter int AW    = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        cfg_width,
  input  logic [AW-1:0]        cfg_height,
  input  logic                 cfg_pool_en,
  input  logic                 cfg_leaky_en,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] din,
  output logic                 dout_valid,
  output logic signed [DW-1:0] dout,
  output logic                 frame_done
);

  localparam int LB_DEPTH = MAX_W / 2;
  localparam int LBW      = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  function automatic logic signed [DW-1:0] smax(input logic signed [DW-1:0] a,
                                                input logic signed [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Raster position and per-plane configuration
  logic [AW-1:0] col, row;
  logic [AW-1:0] w_q, h_q;
  logic          pool_q, leaky_q;

  logic          plane_start;
  logic [AW-1:0] w_eff, h_eff;
  logic          pool_eff, leaky_eff;
  logic          col_last, row_last, keep;
  logic signed [DW-1:0] l_comb;

  // Stage-1 registers: activated value plus its position metadata
  logic                 s1_valid;
  logic signed [DW-1:0] s1_l;
  logic                 s1_odd_col, s1_odd_row, s1_keep, s1_last, s1_pool;
  logic [LBW-1:0]       s1_idx;

  logic signed [DW-1:0] pair_q;
  logic signed [DW-1:0] hmax;
  logic signed [DW-1:0] lb_rd;
  logic signed [DW-1:0] line_buf [LB_DEPTH];

  // The first beat of a plane must already see the new configuration, so it
  // uses the live cfg_* inputs while every later beat uses the latched copy.
  always_comb begin
    plane_start = (col == '0) && (row == '0);
    w_eff       = plane_start ? cfg_width    : w_q;
    h_eff       = plane_start ? cfg_height   : h_q;
    pool_eff    = plane_start ? cfg_pool_en  : pool_q;
    leaky_eff   = plane_start ? cfg_leaky_en : leaky_q;
    col_last    = (col == w_eff - AW'(1));
    row_last    = (row == h_eff - AW'(1));
    // Trailing column of an odd-width row and trailing row of an odd-height
    // plane never take part in pooling.
    keep        = !(w_eff[0] && col_last) && !(h_eff[0] && row_last);
    l_comb      = (leaky_eff && din[DW-1]) ? (din >>> 3) : din;
  end

  // Latch configuration on the first beat of each plane
  always_ff @(posedge clk) begin
    if (rst) begin
      w_q     <= '0;
      h_q     <= '0;
      pool_q  <= 1'b0;
      leaky_q <= 1'b0;
    end else if (din_valid && plane_start) begin
      w_q     <= cfg_width;
      h_q     <= cfg_height;
      pool_q  <= cfg_pool_en;
      leaky_q <= cfg_leaky_en;
    end
  end

  // Column/row counters advance only on accepted beats
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (din_valid) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + AW'(1);
      end else begin
        col <= col + AW'(1);
      end
    end
  end

  // Stage 1: register the activated value and where it sits in the plane
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_l       <= '0;
      s1_odd_col <= 1'b0;
      s1_odd_row <= 1'b0;
      s1_keep    <= 1'b0;
      s1_last    <= 1'b0;
      s1_pool    <= 1'b0;
      s1_idx     <= '0;
    end else begin
      s1_valid <= din_valid;
      if (din_valid) begin
        s1_l       <= l_comb;
        s1_odd_col <= col[0];
        s1_odd_row <= row[0];
        s1_keep    <= keep;
        s1_last    <= col_last && row_last;
        s1_pool    <= pool_eff;
        s1_idx     <= LBW'(col >> 1);
      end
    end
  end

  always_comb begin
    hmax  = smax(pair_q, s1_l);
    lb_rd = line_buf[s1_idx];
  end

  // Hold the even-column value until its odd-column partner arrives
  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q <= '0;
    end else if (s1_valid && s1_pool && s1_keep && !s1_odd_col) begin
      pair_q <= s1_l;
    end
  end

  // Even rows park their horizontal maxima for the following odd row
  always_ff @(posedge clk) begin
    if (s1_valid && s1_pool && s1_keep && s1_odd_col && !s1_odd_row) begin
      line_buf[s1_idx] <= hmax;
    end
  end

  // Stage 2: output register; dout holds between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      frame_done <= s1_valid && s1_last;
      if (s1_valid) begin
        if (!s1_pool) begin
          dout       <= s1_l;
          dout_valid <= 1'b1;
        end else if (s1_keep && s1_odd_col && s1_odd_row) begin
          dout       <= smax(hmax, lb_rd);
          dout_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_act_pool_2x2.sv
// Directed bench for act_pool_2x2: bypass, pooling with and without input
// gaps, odd dimensions, mid-plane reset and back-to-back planes.
module tb_act_pool_2x2;

  localparam int DW    = 16;
  localparam int MAX_W = 416;
  localparam int AW    = 9;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [AW-1:0]        cfg_width, cfg_height;
  logic                 cfg_pool_en, cfg_leaky_en;
  logic                 din_valid;
  logic signed [DW-1:0] din;
  logic                 dout_valid;
  logic signed [DW-1:0] dout;
  logic                 frame_done;

  act_pool_2x2 #(.DW(DW), .MAX_W(MAX_W), .AW(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .cfg_pool_en  (cfg_pool_en),
    .cfg_leaky_en (cfg_leaky_en),
    .din_valid    (din_valid),
    .din          (din),
    .dout_valid   (dout_valid),
    .dout         (dout),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [DW-1:0] out_q[$];
  int                   out_cyc[$];
  int                   fd_cyc[$];

  // Record every output strobe and frame pulse with its cycle number
  always @(negedge clk) begin
    if (dout_valid) begin
      out_q.push_back(dout);
      out_cyc.push_back(cyc);
    end
    if (frame_done) fd_cyc.push_back(cyc);
  end

  int total = 0;
  int bad   = 0;

  task automatic clear_q();
    out_q.delete();
    out_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic beat(input logic signed [DW-1:0] v, output int bc);
    din_valid = 1'b1;
    din       = v;
    bc        = cyc;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic set_cfg(input int w, input int h, input logic p, input logic lk);
    cfg_width    = AW'(w);
    cfg_height   = AW'(h);
    cfg_pool_en  = p;
    cfg_leaky_en = lk;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    idle(2);
    @(negedge clk);
    total++;
    if (dout !== '0) begin
      bad++;
      $display("FAIL reset_dout: got %0d expected 0", dout);
    end
    total++;
    if (dout_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_dout_valid: got %b expected 0", dout_valid);
    end
    total++;
    if (frame_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_frame_done: got %b expected 0", frame_done);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_q();
  endtask

  task automatic test_bypass();
    logic signed [DW-1:0] vin [4];
    logic signed [DW-1:0] vexp[4];
    int bc[4];
    vin  = '{16'sd100, -16'sd80, 16'sd0, -16'sd1};
    vexp = '{16'sd100, -16'sd10, 16'sd0, -16'sd1};
    set_cfg(4, 1, 1'b0, 1'b1);
    clear_q();
    for (int i = 0; i < 4; i++) beat(vin[i], bc[i]);
    idle(5);
    total++;
    if (out_q.size() !== 4) begin
      bad++;
      $display("FAIL bypass_count: got %0d expected 4", out_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (out_q.size() > i) begin
        total++;
        if (out_q[i] !== vexp[i]) begin
          bad++;
          $display("FAIL bypass_val[%0d]: got %0d expected %0d", i, out_q[i], vexp[i]);
        end
        total++;
        if (out_cyc[i] !== bc[i] + 2) begin
          bad++;
          $display("FAIL bypass_lat[%0d]: got cycle %0d expected %0d", i, out_cyc[i], bc[i] + 2);
        end
      end
    end
    total++;
    if (fd_cyc.size() !== 1 || (fd_cyc.size() == 1 && fd_cyc[0] !== bc[3] + 2)) begin
      bad++;
      $display("FAIL bypass_frame_done: got %0d pulses expected 1 at cycle %0d", fd_cyc.size(), bc[3] + 2);
    end
  endtask

  task automatic test_pool(input bit gaps);
    logic signed [DW-1:0] vin[8];
    int bc[8];
    vin = '{16'sd1, 16'sd5, -16'sd16, -16'sd8, 16'sd3, 16'sd2, -16'sd24, -16'sd40};
    set_cfg(4, 2, 1'b1, 1'b1);
    clear_q();
    for (int i = 0; i < 8; i++) begin
      beat(vin[i], bc[i]);
      if (gaps) idle($urandom_range(0, 3));
    end
    idle(6);
    total++;
    if (out_q.size() !== 2) begin
      bad++;
      $display("FAIL pool_count(gaps=%0d): got %0d expected 2", gaps, out_q.size());
    end
    if (out_q.size() >= 2) begin
      total++;
      if (out_q[0] !== 16'sd5 || out_cyc[0] !== bc[5] + 2) begin
        bad++;
        $display("FAIL pool_out0(gaps=%0d): got %0d at %0d expected 5 at %0d", gaps, out_q[0], out_cyc[0], bc[5] + 2);
      end
      total++;
      if (out_q[1] !== -16'sd1 || out_cyc[1] !== bc[7] + 2) begin
        bad++;
        $display("FAIL pool_out1(gaps=%0d): got %0d at %0d expected -1 at %0d", gaps, out_q[1], out_cyc[1], bc[7] + 2);
      end
    end
    total++;
    if (fd_cyc.size() !== 1 || (fd_cyc.size() == 1 && fd_cyc[0] !== bc[7] + 2)) begin
      bad++;
      $display("FAIL pool_frame_done(gaps=%0d): got %0d pulses expected 1 at cycle %0d", gaps, fd_cyc.size(), bc[7] + 2);
    end
  endtask

  task automatic test_odd_dims();
    int bc[15];
    set_cfg(5, 3, 1'b1, 1'b0);
    clear_q();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        beat(DW'(10 * r + c), bc[r * 5 + c]);
    idle(6);
    total++;
    if (out_q.size() !== 2) begin
      bad++;
      $display("FAIL odd_count: got %0d expected 2", out_q.size());
    end
    if (out_q.size() >= 2) begin
      total++;
      if (out_q[0] !== 16'sd11 || out_cyc[0] !== bc[6] + 2) begin
        bad++;
        $display("FAIL odd_out0: got %0d at %0d expected 11 at %0d", out_q[0], out_cyc[0], bc[6] + 2);
      end
      total++;
      if (out_q[1] !== 16'sd13 || out_cyc[1] !== bc[8] + 2) begin
        bad++;
        $display("FAIL odd_out1: got %0d at %0d expected 13 at %0d", out_q[1], out_cyc[1], bc[8] + 2);
      end
    end
    total++;
    if (fd_cyc.size() !== 1 || (fd_cyc.size() == 1 && fd_cyc[0] !== bc[14] + 2)) begin
      bad++;
      $display("FAIL odd_frame_done: got %0d pulses expected 1 at cycle %0d", fd_cyc.size(), bc[14] + 2);
    end
  endtask

  task automatic test_reset_mid();
    int bc[8];
    int dummy;
    set_cfg(4, 2, 1'b1, 1'b0);
    clear_q();
    beat(16'sd7, dummy);
    beat(16'sd9, dummy);
    beat(16'sd11, dummy);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
    total++;
    if (out_q.size() !== 0 || fd_cyc.size() !== 0) begin
      bad++;
      $display("FAIL rstmid_stale: got %0d outputs %0d pulses expected 0 0", out_q.size(), fd_cyc.size());
    end
    clear_q();
    for (int i = 0; i < 8; i++) beat(DW'(i + 1), bc[i]);
    idle(6);
    total++;
    if (out_q.size() !== 2) begin
      bad++;
      $display("FAIL rstmid_count: got %0d expected 2", out_q.size());
    end
    if (out_q.size() >= 2) begin
      total++;
      if (out_q[0] !== 16'sd6 || out_cyc[0] !== bc[5] + 2) begin
        bad++;
        $display("FAIL rstmid_out0: got %0d at %0d expected 6 at %0d", out_q[0], out_cyc[0], bc[5] + 2);
      end
      total++;
      if (out_q[1] !== 16'sd8 || out_cyc[1] !== bc[7] + 2) begin
        bad++;
        $display("FAIL rstmid_out1: got %0d at %0d expected 8 at %0d", out_q[1], out_cyc[1], bc[7] + 2);
      end
    end
    total++;
    if (fd_cyc.size() !== 1 || (fd_cyc.size() == 1 && fd_cyc[0] !== bc[7] + 2)) begin
      bad++;
      $display("FAIL rstmid_frame_done: got %0d pulses expected 1 at cycle %0d", fd_cyc.size(), bc[7] + 2);
    end
  endtask

  task automatic test_back_to_back();
    int bc_first, bc_last, bc_a, bc_b, dummy;
    int wrong;
    set_cfg(MAX_W, 2, 1'b1, 1'b0);
    clear_q();
    beat(-16'sd32768, bc_first);
    // Next plane's settings applied mid-plane must not disturb this plane
    set_cfg(2, 1, 1'b0, 1'b0);
    for (int i = 1; i < MAX_W; i++) beat(-16'sd32768, dummy);
    for (int i = 0; i < MAX_W; i++) beat(16'sd32767, bc_last);
    beat(16'sd123, bc_a);
    beat(-16'sd8, bc_b);
    idle(6);
    total++;
    if (out_q.size() !== MAX_W / 2 + 2) begin
      bad++;
      $display("FAIL b2b_count: got %0d expected %0d", out_q.size(), MAX_W / 2 + 2);
    end
    if (out_q.size() == MAX_W / 2 + 2) begin
      wrong = 0;
      for (int i = 0; i < MAX_W / 2; i++)
        if (out_q[i] !== 16'sd32767) wrong++;
      total++;
      if (wrong !== 0) begin
        bad++;
        $display("FAIL b2b_pool_vals: got %0d wrong values expected 0 (first=%0d)", wrong, out_q[0]);
      end
      total++;
      if (out_cyc[MAX_W / 2 - 1] !== bc_last + 2) begin
        bad++;
        $display("FAIL b2b_pool_last_lat: got cycle %0d expected %0d", out_cyc[MAX_W / 2 - 1], bc_last + 2);
      end
      total++;
      if (out_q[MAX_W / 2] !== 16'sd123 || out_cyc[MAX_W / 2] !== bc_a + 2) begin
        bad++;
        $display("FAIL b2b_bypass0: got %0d at %0d expected 123 at %0d", out_q[MAX_W / 2], out_cyc[MAX_W / 2], bc_a + 2);
      end
      total++;
      if (out_q[MAX_W / 2 + 1] !== -16'sd8 || out_cyc[MAX_W / 2 + 1] !== bc_b + 2) begin
        bad++;
        $display("FAIL b2b_bypass1: got %0d at %0d expected -8 at %0d", out_q[MAX_W / 2 + 1], out_cyc[MAX_W / 2 + 1], bc_b + 2);
      end
    end
    total++;
    if (fd_cyc.size() !== 2 ||
        (fd_cyc.size() == 2 && (fd_cyc[0] !== bc_last + 2 || fd_cyc[1] !== bc_b + 2))) begin
      bad++;
      $display("FAIL b2b_frame_done: got %0d pulses expected 2 at cycles %0d,%0d", fd_cyc.size(), bc_last + 2, bc_b + 2);
    end
  endtask

  initial begin
    rst       = 1'b1;
    din_valid = 1'b0;
    din       = '0;
    set_cfg(4, 1, 1'b0, 1'b0);
    #1;
    test_reset();
    test_bypass();
    test_pool(1'b0);
    test_pool(1'b1);
    test_odd_dims();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
